// File: rtl/key_encoder8_3.sv
// Debounced 8-to-3 priority encoder for the lab-board key row (bit 7 has highest priority).
// Optional KEYENC_7SEG_EN adds a registered active-low seven-segment view of code_out.
module key_encoder8_3 #(
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_in,
  output logic [2:0] code_out,
  output logic       valid,
  output logic       press_pulse,
  output logic       multi
`ifdef KEYENC_7SEG_EN
  ,
  output logic [6:0] seg_out
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [7:0]       sync_reg;
  logic [7:0]       ks;
  logic [7:0]       snapshot;
  logic [CNT_W-1:0] cnt;

  // Ascending scan so the highest set bit is the one left standing.
  function automatic logic [2:0] top_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic many_bits(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync_reg    <= 8'd0;
      ks          <= 8'd0;
      snapshot    <= 8'd0;
      cnt         <= '0;
      code_out    <= 3'd0;
      valid       <= 1'b0;
      press_pulse <= 1'b0;
      multi       <= 1'b0;
    end else begin
      sync_reg    <= key_in;
      ks          <= sync_reg;
      press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ks != 8'd0) begin
            state    <= DEBOUNCE;
            snapshot <= ks;
            cnt      <= '0;
          end
        end
        DEBOUNCE: begin
          if (ks != snapshot) begin
            if (ks == 8'd0) begin
              state <= IDLE;
            end else begin
              snapshot <= ks;
              cnt      <= '0;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            code_out    <= top_index(snapshot);
            multi       <= many_bits(snapshot);
            press_pulse <= 1'b1;
            valid       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          // Extra or swapped keys while held are deliberately ignored: one event per press.
          if (ks == 8'd0) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (ks != 8'd0) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            valid <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEYENC_7SEG_EN
  function automatic logic [6:0] seg_of(input logic [2:0] code);
    logic [6:0] seg;
    case (code)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
    return seg;
  endfunction

  // Follows code_out one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_out <= 7'b1000000;
    end else begin
      seg_out <= seg_of(code_out);
    end
  end
`endif

endmodule

// File: tb/tb_key_encoder8_3.sv
// Bench for key_encoder8_3 (DEBOUNCE_CYCLES=4): vector table, hand-written corner sequences
// and random key activity, all checked every cycle against a run-length reference model.
module tb_key_encoder8_3;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_in;
  logic [2:0] code_out;
  logic       valid;
  logic       press_pulse;
  logic       multi;
`ifdef KEYENC_7SEG_EN
  logic [6:0] seg_out;
`endif

  always #5 clk = ~clk;

  key_encoder8_3 #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .code_out(code_out),
    .valid(valid),
    .press_pulse(press_pulse),
    .multi(multi)
`ifdef KEYENC_7SEG_EN
    ,
    .seg_out(seg_out)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference model: keys reach the decision point two clocks late; a press is accepted
  // after N+1 consecutive identical nonzero samples, a release after N+1 consecutive zeros.
  logic [7:0] d1, d2, last_ks;
  int         run, zrun;
  bit         pressed;
  logic [2:0] m_code;
  logic       m_multi, m_pulse;
  logic [6:0] m_seg;
  logic [6:0] seg_table [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  function automatic logic [2:0] highest_key(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic model_step();
    logic [7:0] ks;
    if (!rst_n) begin
      d1 = 8'd0; d2 = 8'd0; last_ks = 8'd0;
      run = 0; zrun = 0; pressed = 0;
      m_code = 3'd0; m_multi = 1'b0; m_pulse = 1'b0; m_seg = seg_table[0];
    end else begin
      m_seg = seg_table[m_code];
      ks = d2; d2 = d1; d1 = key_in;
      m_pulse = 1'b0;
      if (!pressed) begin
        if (ks == 8'd0) run = 0;
        else if (run > 0 && ks == last_ks) run++;
        else run = 1;
        last_ks = ks;
        if (run == N + 1) begin
          pressed = 1; m_pulse = 1'b1;
          m_code  = highest_key(ks);
          m_multi = ($countones(ks) > 1);
          run = 0; zrun = 0;
        end
      end else begin
        if (ks == 8'd0) zrun++;
        else zrun = 0;
        if (zrun == N + 1) begin
          pressed = 0; zrun = 0; run = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("code_out", 32'(code_out), 32'(m_code));
    chk("valid", 32'(valid), 32'(pressed));
    chk("press_pulse", 32'(press_pulse), 32'(m_pulse));
    chk("multi", 32'(multi), 32'(m_multi));
`ifdef KEYENC_7SEG_EN
    chk("seg_out", 32'(seg_out), 32'(m_seg));
`endif
    if (press_pulse === 1'b1) pulses++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  typedef struct {
    logic [7:0] key;
    logic [2:0] code;
    logic       multi;
  } vec_t;

  vec_t vecs [8];
  int   p0;

  initial begin
    vecs[0] = '{8'h20, 3'd5, 1'b0};
    vecs[1] = '{8'h05, 3'd2, 1'b1};
    vecs[2] = '{8'h80, 3'd7, 1'b0};
    vecs[3] = '{8'h01, 3'd0, 1'b0};
    vecs[4] = '{8'hFF, 3'd7, 1'b1};
    vecs[5] = '{8'h18, 3'd4, 1'b1};
    vecs[6] = '{8'h02, 3'd1, 1'b0};
    vecs[7] = '{8'h40, 3'd6, 1'b0};

    rst_n = 1'b0; key_in = 8'h00;
    run_cycles(2);
    chk("reset code_out", 32'(code_out), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset press_pulse", 32'(press_pulse), 32'd0);
    chk("reset multi", 32'(multi), 32'd0);
    rst_n = 1'b1;
    run_cycles(2);

    // Clean press/release per table entry
    for (int v = 0; v < 8; v++) begin
      p0 = pulses;
      key_in = vecs[v].key;
      run_cycles(N + 6);
      chk("table pulses", 32'(pulses - p0), 32'd1);
      chk("table code", 32'(code_out), 32'(vecs[v].code));
      chk("table multi", 32'(multi), 32'(vecs[v].multi));
      chk("table valid held", 32'(valid), 32'd1);
      key_in = 8'h00;
      run_cycles(N + 6);
      chk("table valid released", 32'(valid), 32'd0);
      chk("table code held", 32'(code_out), 32'(vecs[v].code));
    end

    // Key added while held: no re-encode
    p0 = pulses;
    key_in = 8'h05; run_cycles(N + 6);
    key_in = 8'h85; run_cycles(N + 6);
    chk("swap pulses", 32'(pulses - p0), 32'd1);
    chk("swap code", 32'(code_out), 32'd2);
    key_in = 8'h00; run_cycles(N + 6);

    // Press bounce then stable; release bounce shorter than the debounce window
    p0 = pulses;
    for (int b = 0; b < 5; b++) begin
      key_in = (b % 2 == 0) ? 8'h08 : 8'h00;
      run_cycles(2);
    end
    key_in = 8'h08; run_cycles(N + 6);
    chk("bounce pulses", 32'(pulses - p0), 32'd1);
    chk("bounce code", 32'(code_out), 32'd3);
    p0 = pulses;
    for (int b = 0; b < 4; b++) begin
      key_in = (b % 2 == 0) ? 8'h00 : 8'h08;
      run_cycles(2);
      chk("release bounce valid", 32'(valid), 32'd1);
    end
    run_cycles(4);
    chk("release bounce pulses", 32'(pulses - p0), 32'd0);
    key_in = 8'h00; run_cycles(N + 6);

    // Reset mid-debounce with key held
    p0 = pulses;
    key_in = 8'h80; run_cycles(4);
    rst_n = 1'b0; run_cycles(1);
    chk("midreset pulses", 32'(pulses - p0), 32'd0);
    chk("midreset valid", 32'(valid), 32'd0);
    rst_n = 1'b1; run_cycles(N + 6);
    chk("after reset pulses", 32'(pulses - p0), 32'd1);
    chk("after reset code", 32'(code_out), 32'd7);
    key_in = 8'h00; run_cycles(N + 6);

    // Two presses separated by a 20-clock gap
    p0 = pulses;
    key_in = 8'h01; run_cycles(N + 6);
    chk("first press valid", 32'(valid), 32'd1);
    key_in = 8'h00; run_cycles(20);
    chk("gap valid", 32'(valid), 32'd0);
    key_in = 8'h01; run_cycles(N + 6);
    chk("second press valid", 32'(valid), 32'd1);
    chk("two presses pulses", 32'(pulses - p0), 32'd2);
    chk("two presses code", 32'(code_out), 32'd0);
    key_in = 8'h00; run_cycles(N + 6);

    // Random key activity with occasional resets
    for (int r = 0; r < 400; r++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      case ($urandom_range(0, 3))
        0:       key_in = 8'h00;
        1:       key_in = 8'h01 << $urandom_range(0, 7);
        2:       key_in = 8'(($urandom_range(0, 1) != 0) ? 8'h24 : 8'h0C);
        default: key_in = 8'($urandom);
      endcase
      run_cycles($urandom_range(1, 9));
    end
    rst_n = 1'b1; key_in = 8'h00;
    run_cycles(N + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
